// File: rtl/cache_arb_pkg.sv
// Shared constants for the two-port cache arbiter: default widths,
// FSM state encoding and the timeout counter width helper.
package cache_arb_pkg;

  localparam int ADDR_W_DEF  = 16;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 64;

  // 2-bit FSM encoding, kept as plain constants so older blocks can share it
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Port identifiers as stored in the grant / last-served registers
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // Timeout counter width; a degenerate TIMEOUT of 1 still needs one bit
  function automatic int cnt_width(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/cache_rr_pick.sv
// Two-way round-robin pick. Purely combinational: with both requests up,
// the port that was not served last wins.
module cache_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       valid
);

  // One-hot grant from the request pair and the last-served port
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  assign valid = |req;

endmodule

// File: rtl/cache_port_arbiter.sv
// Two-port arbiter in front of a single cache controller. One command is
// in flight at a time: IDLE grants and latches, BUSY drives the controller
// until ready or timeout, RESP returns a one-cycle ack to the granted port.
module cache_port_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDRESSLENGTH = ADDR_W_DEF,
  parameter int DATALENGTH    = DATA_W_DEF,
  parameter int TIMEOUT       = TIMEOUT_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     p0_req,
  input  logic                     p0_we,
  input  logic [ADDRESSLENGTH-1:0] p0_addr,
  input  logic [DATALENGTH-1:0]    p0_wdata,
  output logic                     p0_ack,
  output logic                     p0_err,
  output logic [DATALENGTH-1:0]    p0_rdata,
  input  logic                     p1_req,
  input  logic                     p1_we,
  input  logic [ADDRESSLENGTH-1:0] p1_addr,
  input  logic [DATALENGTH-1:0]    p1_wdata,
  output logic                     p1_ack,
  output logic                     p1_err,
  output logic [DATALENGTH-1:0]    p1_rdata,
  output logic                     ctl_re,
  output logic                     ctl_we,
  output logic [ADDRESSLENGTH-1:0] ctl_addr,
  output logic [DATALENGTH-1:0]    ctl_wdata,
  input  logic [DATALENGTH-1:0]    ctl_rdata,
  input  logic                     ctl_ready
);

  localparam int              CW       = cnt_width(TIMEOUT);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

  logic [1:0]               state_q;
  logic                     gnt_q;       // port owning the current command
  logic                     last_q;      // last port that received an ack
  logic                     served_q;    // any ack since reset
  logic                     cmd_we_q;
  logic [ADDRESSLENGTH-1:0] cmd_addr_q;
  logic [DATALENGTH-1:0]    cmd_wdata_q;
  logic [CW-1:0]            cnt_q;
  logic                     rsp_err_q;
  logic [DATALENGTH-1:0]    rsp_rdata_q;

  logic [1:0] pick_gnt;
  logic       pick_vld;
  logic       pick_p1;
  logic       busy, resp, timed_out;

  // Until something has been served, pretend port 1 went last so port 0
  // wins the first tie while the pointer itself still resets to port 0.
  cache_rr_pick u_pick (
    .req   ({p1_req, p0_req}),
    .last  (last_q | ~served_q),
    .gnt   (pick_gnt),
    .valid (pick_vld)
  );

  assign pick_p1   = (pick_gnt == 2'b10);
  assign busy      = (state_q == ST_BUSY);
  assign resp      = (state_q == ST_RESP);
  assign timed_out = (cnt_q == CNT_LAST);

  // FSM, command latch, timeout counter and response capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      gnt_q       <= PORT0;
      last_q      <= PORT0;
      served_q    <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cnt_q       <= '0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_vld) begin
            gnt_q       <= pick_p1 ? PORT1 : PORT0;
            cmd_we_q    <= pick_p1 ? p1_we    : p0_we;
            cmd_addr_q  <= pick_p1 ? p1_addr  : p0_addr;
            cmd_wdata_q <= pick_p1 ? p1_wdata : p0_wdata;
            cnt_q       <= '0;
            state_q     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // saturate so a stuck state can never wrap back into range
          if (!timed_out) cnt_q <= cnt_q + 1'b1;
          // ready beats a same-cycle timeout
          if (ctl_ready) begin
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= cmd_we_q ? '0 : ctl_rdata;
            state_q     <= ST_RESP;
          end else if (timed_out) begin
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          last_q   <= gnt_q;
          served_q <= 1'b1;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Controller strobes drop as soon as ready shows, so nothing relaunches
  assign ctl_re    = busy & ~cmd_we_q & ~ctl_ready;
  assign ctl_we    = busy &  cmd_we_q & ~ctl_ready;
  assign ctl_addr  = busy ? cmd_addr_q  : '0;
  assign ctl_wdata = busy ? cmd_wdata_q : '0;

  // Responses are decoded from state so reset clears them immediately
  assign p0_ack   = resp & (gnt_q == PORT0);
  assign p1_ack   = resp & (gnt_q == PORT1);
  assign p0_err   = p0_ack & rsp_err_q;
  assign p1_err   = p1_ack & rsp_err_q;
  assign p0_rdata = p0_ack ? rsp_rdata_q : '0;
  assign p1_rdata = p1_ack ? rsp_rdata_q : '0;

endmodule
